// File: rtl/elastic_pipe_reg_if.sv
// Handshake bundle for elastic_pipe_reg: producer side (in_*) and consumer side (out_*).
// The slave modport is the buffer itself; the master modport is the surrounding datapath.
interface elastic_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH-entry FIFO of LANES x DATA_W operand entries with registered head.
// Optional occupancy statistics (hwm, stall_cnt) are enabled by defining ELASTIC_PIPE_REG_STATS_EN.
module elastic_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    elastic_pipe_reg_if.slave bus,
`ifdef ELASTIC_PIPE_REG_STATS_EN
    output logic [CNT_W-1:0]  hwm,
    output logic [15:0]       stall_cnt,
`endif
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int W     = LANES * DATA_W;

    logic [W-1:0]     mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [W-1:0]     out_data_reg, out_data_next;
    logic [DEPTH-1:0] wr_en;
    logic             in_ready;
    logic             push;
    logic             pop;

    // Ready comes only from registered occupancy and flush, never from out_ready.
    assign in_ready = (count_reg < CNT_W'(DEPTH)) && !flush;
    assign push     = bus.in_valid && in_ready;
    assign pop      = (count_reg != '0) && bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        out_data_next = out_data_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
            // Preload the register with whatever will be the head after this edge;
            // it bypasses storage when the new head is the entry being written now.
            if (count_next != '0) begin
                if (push && (wr_ptr_reg == rd_ptr_next))
                    out_data_next = bus.in_data;
                else
                    out_data_next = mem_reg[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wr_en[i]) mem_reg[i] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            out_data_reg <= out_data_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (count_reg != '0);
    assign bus.out_data  = out_data_reg;
    assign count         = count_reg;

`ifdef ELASTIC_PIPE_REG_STATS_EN
    logic [CNT_W-1:0] hwm_reg;
    logic [15:0]      stall_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_reg   <= '0;
            stall_reg <= '0;
        end else if (flush) begin
            hwm_reg   <= '0;
            stall_reg <= '0;
        end else begin
            if (count_next > hwm_reg) hwm_reg <= count_next;
            if (bus.in_valid && !in_ready && (stall_reg != 16'hFFFF))
                stall_reg <= stall_reg + 16'd1;
        end
    end

    assign hwm       = hwm_reg;
    assign stall_cnt = stall_reg;
`endif
endmodule
